dma_rd_burst_ctrl: RTL

//  Upstream stage of the AXI read channel master (dma_axi_r). Takes one read-transfer command
//  (start address, word count) and splits it into AXI INCR bursts.

---
 rtl/dma_rd_burst_ctrl_pkg.sv | 16 +
 rtl/dma_rd_burst_len.sv | 29 ++
 rtl/dma_rd_burst_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dma_rd_burst_ctrl_pkg.sv
// Shared widths, FSM state codes and 4 KB page constants for the DMA read burst controller.
package dma_rd_burst_ctrl_pkg;

   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_LEN_W  = 8;

   localparam int unsigned PAGE_BYTES = 4096;
   localparam int unsigned PAGE_OFF_W = 12;

   typedef enum logic [1:0] {
      BRC_IDLE  = 2'd0,
      BRC_ISSUE = 2'd1,
      BRC_DATA  = 2'd2
   } brc_state_e;

endpackage

// File: rtl/dma_rd_burst_len.sv
// Burst sizing: beats = min(remaining words, 2**LEN_W, page limit). Purely combinational.
module dma_rd_burst_len #(
   parameter int unsigned CNT_W = 24,
   parameter int unsigned LEN_W = 8,
   parameter int unsigned LIM_W = 13
) (
   input  logic [CNT_W-1:0] remaining_i,
   input  logic [LIM_W-1:0] page_lim_i,
   output logic [LEN_W:0]   beats_o
);

   localparam int unsigned CW = (CNT_W > LIM_W) ? CNT_W : LIM_W;

   logic [CW-1:0] rem_w;
   logic [CW-1:0] lim_w;
   logic [CW-1:0] max_w;
   logic [CW-1:0] cap_w;
   logic [CW-1:0] min_w;

   always_comb begin
      rem_w   = CW'(remaining_i);
      lim_w   = CW'(page_lim_i);
      max_w   = CW'(1) << LEN_W;
      cap_w   = (lim_w < max_w) ? lim_w : max_w;
      min_w   = (rem_w < cap_w) ? rem_w : cap_w;
      beats_o = (LEN_W+1)'(min_w);
   end

endmodule

// File: rtl/dma_rd_burst_ctrl.sv
// Splits a (start address, word count) read command into AXI INCR bursts for dma_axi_r.
// Define DMA_RD_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module dma_rd_burst_ctrl
   import dma_rd_burst_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = AXI_ADDR_W,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = AXI_LEN_W,
   parameter int unsigned CNT_W  = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [CNT_W-1:0]  cmd_words,
   output logic              busy,
   output logic              done,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [LEN_W-1:0]  rd_len,
   input  logic              rd_ready,
   input  logic              rd_dma_ready
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned OFF   = $clog2(BYTES);
   localparam int unsigned LIM_W = (LEN_W + 1 > PAGE_OFF_W + 1) ? LEN_W + 1 : PAGE_OFF_W + 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

   brc_state_e        state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [LEN_W-1:0]  beat_q, beat_d;

   logic [LIM_W-1:0]  page_lim;
   logic [LEN_W:0]    beats_w;
   logic [LEN_W:0]    cur_beats;
   logic [CNT_W-1:0]  rem_after;
   logic [ADDR_W-1:0] addr_after;

`ifdef DMA_RD_4K_SPLIT_EN
   logic [LIM_W-1:0]  page_room;
   assign page_room = LIM_W'(PAGE_BYTES) - LIM_W'(addr_q[PAGE_OFF_W-1:0]);
   assign page_lim  = page_room >> OFF;
`else
   assign page_lim  = LIM_W'(1) << LEN_W;
`endif

   dma_rd_burst_len #(
      .CNT_W (CNT_W),
      .LEN_W (LEN_W),
      .LIM_W (LIM_W)
   ) u_len (
      .remaining_i (rem_q),
      .page_lim_i  (page_lim),
      .beats_o     (beats_w)
   );

   // Current burst size is recovered from rd_len so the advance uses what the master was told.
   assign cur_beats  = {1'b0, len_q} + (LEN_W+1)'(1);
   assign rem_after  = rem_q - CNT_W'(cur_beats);
   assign addr_after = addr_q + (ADDR_W'(cur_beats) << OFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BRC_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      addr_d  = addr_q;
      len_d   = len_q;
      rem_d   = rem_q;
      beat_d  = beat_q;

      case (state_q)
         BRC_IDLE: begin
            if (cmd_start) begin
               if (cmd_words != '0) begin
                  addr_d  = cmd_addr & ALIGN_MASK;
                  rem_d   = cmd_words;
                  busy_d  = 1'b1;
                  state_d = BRC_ISSUE;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         BRC_ISSUE: begin
            if (rd_dma_ready) begin
               len_d   = LEN_W'(beats_w - (LEN_W+1)'(1));
               valid_d = 1'b1;
               beat_d  = '0;
               state_d = BRC_DATA;
            end
         end
         BRC_DATA: begin
            if (rd_ready) begin
               valid_d = 1'b0;
               beat_d  = beat_q + LEN_W'(1);
               if (beat_q == len_q) begin
                  addr_d = addr_after;
                  rem_d  = rem_after;
                  if (rem_after == '0) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = BRC_IDLE;
                  end else begin
                     state_d = BRC_ISSUE;
                  end
               end
            end
         end
         default: state_d = BRC_IDLE;
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_valid = valid_q;
   assign rd_addr  = addr_q;
   assign rd_len   = len_q;

endmodule
